// File: rtl/alu_seq_pkg.sv
// Shared encodings, state enum and default sizing for the ALU issue sequencer.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (see alu_sequencer.sv).
package alu_seq_pkg;

    localparam int N_DEF       = 32;
    localparam int NREG_DEF    = 4;
    localparam int ALU_LAT_DEF = 2;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_NOT = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_AND = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WB
    } state_e;

    // Encodings 110 and 111 have no defined ALU function.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x N flop register file: two operand read ports, host read port, and a
// write path where writeback beats a same-address host write.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr_a,
    output logic [N-1:0]  rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [N-1:0]  rd_data_b,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [N-1:0]  wb_data,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [N-1:0]  host_wdata,
    output logic [N-1:0]  host_rdata
);

    logic [N-1:0] mem [NREG];

    // NOTE: this array is small and built from flops, so clearing it on reset is
    // legal; a RAM-inferred array must not be reset like this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_we && wb_addr == AW'(i))
                    mem[i] <= wb_data;
                else if (host_we && host_addr == AW'(i))
                    mem[i] <= host_wdata;
            end
        end
    end

    assign rd_data_a  = mem[rd_addr_a];
    assign rd_data_b  = mem[rd_addr_b];
    assign host_rdata = mem[host_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue stage for the registered ALU: accept, read operands, wait ALU_LAT, write back.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap ops 110/111 with an illegal_op pulse.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_src_a,
    input  logic [AW-1:0] instr_src_b,
    output logic [2:0]    alu_op,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_result,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [N-1:0]  host_wdata,
    output logic [N-1:0]  host_rdata,
    output logic          done,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    output logic          illegal_op,
`endif
    output logic          busy
);

    localparam int CW = $clog2(ALU_LAT + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] dst_q;
    logic [N-1:0]  rd_a;
    logic [N-1:0]  rd_b;
    logic          trap;

    assign instr_ready = (state == ST_IDLE);
    assign busy        = ~instr_ready;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign trap = is_illegal_op(instr_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_op <= 1'b0;
        else        illegal_op <= instr_valid && instr_ready && trap;
    end
`else
    assign trap = 1'b0;
`endif

    alu_seq_regfile #(.N(N), .NREG(NREG), .AW(AW)) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_a  (instr_src_a),
        .rd_data_a  (rd_a),
        .rd_addr_b  (instr_src_b),
        .rd_data_b  (rd_b),
        .wb_we      (state == ST_WB),
        .wb_addr    (dst_q),
        .wb_data    (alu_result),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values (operands are read as they were before the accept edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dst_q  <= '0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && !trap) begin
                        alu_op <= instr_op;
                        alu_a  <= rd_a;
                        alu_b  <= rd_b;
                        dst_q  <= instr_dst;
                        cnt    <= CW'(ALU_LAT);
                        state  <= ST_WAIT;
                    end
                end
                // Leave WAIT on the edge the count reaches zero so WB samples the ALU output.
                ST_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_WB;
                end
                ST_WB: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 2-cycle ALU.
// Honors ALU_SEQ_ILLEGAL_TRAP_EN to match the DUT build.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [1:0]  instr_dst, instr_src_a, instr_src_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        host_we;
    logic [1:0]  host_addr, drv_addr, mon_addr;
    logic        mon_sel;
    logic [31:0] host_wdata, host_rdata;
    logic        done, busy;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    always #5 clk = ~clk;

    assign host_addr = mon_sel ? mon_addr : drv_addr;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_src_a (instr_src_a),
        .instr_src_b (instr_src_b),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .done        (done),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        .illegal_op  (illegal_op),
`endif
        .busy        (busy)
    );

    // Two-stage ALU: capture op/operands, then register the result.
    logic [2:0]  cap_op;
    logic [31:0] cap_a, cap_b;
    always @(posedge clk) begin
        cap_op <= alu_op;
        cap_a  <= alu_a;
        cap_b  <= alu_b;
        case (cap_op)
            3'b001:  alu_result <= ~cap_a;
            3'b010:  alu_result <= cap_a + cap_b;
            3'b011:  alu_result <= cap_a - cap_b;
            3'b100:  alu_result <= cap_a | cap_b;
            3'b101:  alu_result <= cap_a & cap_b;
            default: alu_result <= cap_a;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  dst;
        logic [31:0] val;
        int          pre;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_unexpected", {31'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                mon_addr = e.dst;
                mon_sel  = 1'b1;
                #1;
                check("wb_value", host_rdata, e.val);
                check("done_latency", cyc - e.pre, 32'd4);
                mon_sel = 1'b0;
            end
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        host_we = 1'b1; drv_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        drv_addr = a;
        #1;
        d = host_rdata;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                         input logic [1:0] b, input bit push, input logic [31:0] val,
                         output int gap);
        gap = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_dst = dst;
        instr_src_a = a; instr_src_b = b;
        while (!instr_ready && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        if (!instr_ready) check("ready_timeout", {31'b0, instr_ready}, 32'h1);
        if (push) sb.push_back('{dst, val, cyc});
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", sb.size(), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [31:0] d;
        rst_n = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
        instr_src_a = '0; instr_src_b = '0; host_we = 1'b0; drv_addr = '0;
        mon_addr = '0; mon_sel = 1'b0; host_wdata = '0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_ready", {31'b0, instr_ready}, 32'h1);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_alu_op", {29'b0, alu_op}, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            check("rst_rf", d, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD r0 = 5 + 3; ALU drive retained afterwards
        host_write(2'd1, 32'd5);
        host_write(2'd2, 32'd3);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 32'd8, g);
        wait_idle();
        check("hold_alu_op", {29'b0, alu_op}, 32'h2);
        check("hold_alu_a", alu_a, 32'd5);
        check("hold_alu_b", alu_b, 32'd3);

        // 2: SUB wraps, NOT of all-ones
        host_write(2'd1, 32'd3);
        host_write(2'd2, 32'd5);
        issue(OP_SUB, 2'd3, 2'd1, 2'd2, 1'b1, 32'hFFFF_FFFE, g);
        wait_idle();
        host_write(2'd2, 32'hFFFF_FFFF);
        issue(OP_NOT, 2'd0, 2'd2, 2'd2, 1'b1, 32'h0, g);
        wait_idle();
        issue(OP_OR, 2'd1, 2'd3, 2'd0, 1'b1, 32'hFFFF_FFFE, g);
        wait_idle();

        // 3: back-to-back, second reads the first result
        host_write(2'd1, 32'd5);
        host_write(2'd2, 32'd3);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 32'd8, g);
        issue(OP_MOV, 2'd3, 2'd0, 2'd0, 1'b1, 32'd8, g);
        check("b2b_ready_gap", g, 32'd3);
        wait_idle();

        // 4: host write collides with WB; then a different address in the WB cycle
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 32'd8, g);
        repeat (3) @(negedge clk);
        host_we = 1'b1; drv_addr = 2'd0; host_wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1 host_we = 1'b0;
        wait_idle();
        issue(OP_AND, 2'd0, 2'd1, 2'd2, 1'b1, 32'd1, g);
        repeat (3) @(negedge clk);
        host_we = 1'b1; drv_addr = 2'd1; host_wdata = 32'd7;
        @(posedge clk);
        #1 host_we = 1'b0;
        wait_idle();
        peek(2'd1, d);
        check("host_wr_parallel", d, 32'd7);

        // 5: reset while waiting on the ALU
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 32'h0, g);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, instr_ready}, 32'h1);
        check("midrst_alu_op", {29'b0, alu_op}, 32'h0);
        check("midrst_alu_a", alu_a, 32'h0);
        check("midrst_alu_b", alu_b, 32'h0);
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            check("midrst_rf", d, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        peek(2'd3, d);
        check("midrst_no_wb", d, 32'h0);

        // 6: op 110
        host_write(2'd1, 32'd9);
        host_write(2'd3, 32'h55);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        issue(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 32'h0, g);
        @(negedge clk);
        check("trap_pulse", {31'b0, illegal_op}, 32'h1);
        check("trap_ready", {31'b0, instr_ready}, 32'h1);
        @(negedge clk);
        check("trap_pulse_end", {31'b0, illegal_op}, 32'h0);
        repeat (5) @(negedge clk);
        peek(2'd3, d);
        check("trap_rf_kept", d, 32'h55);
`else
        issue(3'b110, 2'd3, 2'd1, 2'd2, 1'b1, 32'd9, g);
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        check("sb_drain", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
